switch_route_arbiter: RTL and testbench
=======================================

# switch_route_arbiter

Dynamic route arbiter for the generated N×M switch. Each switch input presents a valid request and a destination output index. The block grants each output to at most one requesting input using per-output round-robin, and holds that grant until one transfer completes. It drives the switch's `cfg_route_table` directly, replacing static configuration when routes are data-dependent. It also raises the switch-style error pair when requests are malformed.

## Interface
Parameters:
- `NUM_IN`, default 2: number of switch inputs (≥1).
- `NUM_OUT`, default 2: number of switch outputs (≥1).
- `DEST_W`, default 1: width of each destination field; must satisfy 2^DEST_W ≥ NUM_OUT.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, NUM_IN: per-input request. Mirrors the switch `inN_valid`.
- `in_dest`, input, NUM_IN*DEST_W: destination of input i at bits [i*DEST_W +: DEST_W].
- `out_ready`, input, NUM_OUT: mirrors the switch `outN_ready`.
- `route_table`, output, NUM_OUT*NUM_IN: one-hot-per-output grant. Bit j*NUM_IN+i set means out j ← in i. Connects to the switch `cfg_route_table`.
- `busy`, output, NUM_OUT: output j currently holds a grant.
- `error_valid`, output, 1: sticky error flag.
- `error_code`, output, 16: code of the first error seen.
- `stat_xfer`, output, NUM_OUT*16: per-output transfer counters (see Configuration).

## Operation
- Per output j, state is either IDLE or LOCKED(i), plus a round-robin pointer `ptr[j]` in 0..NUM_IN-1.
- Request: input i requests output j when `in_valid[i]` is high and `in_dest[i] == j`. Each input requests at most one output, so grants never conflict across outputs.
- IDLE → LOCKED(i): taken on the edge where at least one input requests j. The winner is the first requester scanning i = ptr[j], ptr[j]+1, …, modulo NUM_IN.
- LOCKED(i) → IDLE, normal completion: on an edge where `in_valid[i] & out_ready[j]` (one transfer) completes, the grant clears and `ptr[j]` ← (i+1) mod NUM_IN.
- LOCKED(i) → IDLE, abandonment: if `in_valid[i]` is low while LOCKED(i) with no transfer, the grant clears and `ptr[j]` is unchanged. This raises error code 0x0002.
- A change of `in_dest[i]` while LOCKED(i) is ignored. The grant holds until completion or abandonment.
- Bad destination: `in_valid[i]` with `in_dest[i] >= NUM_OUT` raises error code 0x0001. That request is never granted.
- Error register: `error_valid` and `error_code` latch the first error. Later errors do not overwrite them. They clear only on `rst`. If two error types occur in the same cycle, 0x0001 wins.
- Output mapping: `route_table` bit j*NUM_IN+i = (state[j] == LOCKED(i)). `busy[j]` = (state[j] != IDLE).

## Timing
- Reset, synchronous: all outputs IDLE, all `ptr` = 0, `route_table` = 0, `busy` = 0, `error_valid` = 0, `error_code` = 0, `stat_xfer` = 0.
- Outputs come straight from registers; there are no combinational input→output paths.
- Grant latency: a request sampled at edge N yields `route_table` set after edge N. The first transfer through the switch can occur in cycle N+1.
- Re-grant: release and new grant cannot share an edge. After a completion at edge M, output j is IDLE during cycle M+1, and the next grant appears after edge M+1. Peak throughput is 1 transfer per 2 cycles per output.
- `rst` asserted mid-transfer clears the grant immediately. No transfer is counted on that edge.
- Wrap-around: `ptr` = NUM_IN-1 advances to 0 after a completion.

## Configuration
- Macro: `LOOM_SWITCH_ARB_STATS_EN`.
- Defined:
  - `stat_xfer[j*16 +: 16]` increments on each normal completion at output j.
  - The counter saturates at 0xFFFF.
  - It resets to 0.
- Undefined: the `stat_xfer` port is still present but tied to 0. No counter registers are built.

## Test plan
- Reset, then idle for 3 cycles: expect `route_table` = 4'b0000, `error_valid` = 0, `error_code` = 0x0000.
- Diagonal route: in0→dest 0, in1→dest 1, both valid, `out_ready` = 2'b11.
  - After 1 edge: `route_table` = 4'b1001.
  - Both grants clear on the next edge; each `stat_xfer` = 1 when the macro is defined.
- Contention, round-robin: in0 and in1 both target dest 0, `out_ready[0]` = 1, held 6 cycles.
  - Grant sequence for out0: in0, idle, in1, idle, in0.
  - `route_table[1:0]` cycles 01 → 00 → 10 → 00 → 01.
- Backpressure hold: in0→dest 1 with `out_ready[1]` = 0 for 4 cycles.
  - `route_table` = 4'b0100 stays stable.
  - Raising `out_ready[1]` releases the grant on that edge.
- Errors:
  - With NUM_OUT = 3 and DEST_W = 2, in0 requests dest 3: expect `error_valid` = 1 and `error_code` = 0x0001 after one edge, with no grant.
  - A subsequent abandonment leaves `error_code` = 0x0001.
  - A separate run with abandonment only yields 0x0002.
- Reset mid-grant: assert `rst` while `route_table` = 4'b0001. After that edge expect all-zero outputs, and `ptr[0]` = 0, so in1 vs in0 contention is next granted to in0.

Source files
------------

// File: rtl/switch_route_arbiter_if.sv
// Request/grant bundle between the switch datapath and switch_route_arbiter.
// master drives requests and readiness; slave (the arbiter) drives routes and status.
interface switch_route_arbiter_if #(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int DEST_W  = 1
);
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*DEST_W-1:0]  in_dest;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*NUM_IN-1:0] route_table;
    logic [NUM_OUT-1:0]        busy;
    logic                      error_valid;
    logic [15:0]               error_code;
    logic [NUM_OUT*16-1:0]     stat_xfer;

    modport master (
        output in_valid, in_dest, out_ready,
        input  route_table, busy, error_valid, error_code, stat_xfer
    );

    modport slave (
        input  in_valid, in_dest, out_ready,
        output route_table, busy, error_valid, error_code, stat_xfer
    );
endinterface

// File: rtl/switch_route_arbiter.sv
// Per-output round-robin route arbiter driving the switch cfg_route_table.
// Optional per-output transfer counters are built when LOOM_SWITCH_ARB_STATS_EN is defined.
module switch_route_arbiter #(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int DEST_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    switch_route_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t            r_state     [NUM_OUT];
    logic [IDX_W-1:0]  r_owner     [NUM_OUT];
    logic [IDX_W-1:0]  r_ptr       [NUM_OUT];
    state_t            w_state_nxt [NUM_OUT];
    logic [IDX_W-1:0]  w_owner_nxt [NUM_OUT];
    logic [IDX_W-1:0]  w_ptr_nxt   [NUM_OUT];
    logic [NUM_IN-1:0] w_req       [NUM_OUT];
    logic [NUM_OUT-1:0] w_done;
    logic [NUM_OUT-1:0] w_abandon;
    logic [NUM_IN-1:0]  w_bad;
    logic               r_error_valid;
    logic [15:0]        r_error_code;

    // Request matrix; out-of-range destinations are flagged and never request anything.
    always_comb begin
        w_bad = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            w_req[j] = '0;
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (bus.in_valid[i]) begin
                if (32'(bus.in_dest[i*DEST_W +: DEST_W]) >= 32'(NUM_OUT)) begin
                    w_bad[i] = 1'b1;
                end else begin
                    for (int unsigned j = 0; j < NUM_OUT; j++) begin
                        if (bus.in_dest[i*DEST_W +: DEST_W] == DEST_W'(j)) begin
                            w_req[j][i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin : next_state
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            w_state_nxt[j] = r_state[j];
            w_owner_nxt[j] = r_owner[j];
            w_ptr_nxt[j]   = r_ptr[j];
            w_done[j]      = 1'b0;
            w_abandon[j]   = 1'b0;
            case (r_state[j])
                ST_IDLE: begin
                    found = 1'b0;
                    for (int unsigned k = 0; k < NUM_IN; k++) begin
                        idx = 32'(r_ptr[j]) + k;
                        if (idx >= 32'(NUM_IN)) begin
                            idx = idx - 32'(NUM_IN);
                        end
                        if (!found && w_req[j][IDX_W'(idx)]) begin
                            found          = 1'b1;
                            w_owner_nxt[j] = IDX_W'(idx);
                        end
                    end
                    if (found) begin
                        w_state_nxt[j] = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Grant is held regardless of the owner's current destination.
                    if (bus.in_valid[r_owner[j]] && bus.out_ready[j]) begin
                        w_done[j]      = 1'b1;
                        w_state_nxt[j] = ST_IDLE;
                    end else if (!bus.in_valid[r_owner[j]]) begin
                        w_abandon[j]   = 1'b1;
                        w_state_nxt[j] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[j] = ST_IDLE;
                end
            endcase
            if (w_done[j]) begin
                w_ptr_nxt[j] = (r_owner[j] == IDX_W'(NUM_IN - 1)) ? '0
                                                                  : r_owner[j] + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (rst) begin
                r_state[j] <= ST_IDLE;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
            end else begin
                r_state[j] <= w_state_nxt[j];
                r_owner[j] <= w_owner_nxt[j];
                r_ptr[j]   <= w_ptr_nxt[j];
            end
        end
    end

    // First error wins; a bad destination outranks an abandonment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error_valid <= 1'b0;
            r_error_code  <= '0;
        end else if (!r_error_valid) begin
            if (|w_bad) begin
                r_error_valid <= 1'b1;
                r_error_code  <= 16'h0001;
            end else if (|w_abandon) begin
                r_error_valid <= 1'b1;
                r_error_code  <= 16'h0002;
            end
        end
    end

    always_comb begin : outputs
        bus.route_table = '0;
        bus.busy        = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            bus.busy[j] = (r_state[j] == ST_LOCKED);
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                bus.route_table[j*NUM_IN + i] = (r_state[j] == ST_LOCKED) &&
                                                (r_owner[j] == IDX_W'(i));
            end
        end
        bus.error_valid = r_error_valid;
        bus.error_code  = r_error_code;
    end

`ifdef LOOM_SWITCH_ARB_STATS_EN
    logic [15:0] r_stat [NUM_OUT];

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (rst) begin
                r_stat[j] <= '0;
            end else if (w_done[j] && (r_stat[j] != 16'hFFFF)) begin
                r_stat[j] <= r_stat[j] + 16'd1;
            end
        end
    end

    always_comb begin
        bus.stat_xfer = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            bus.stat_xfer[j*16 +: 16] = r_stat[j];
        end
    end
`else
    assign bus.stat_xfer = '0;
`endif

endmodule

// File: tb/tb_switch_route_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// Two instances: 2x2 (DEST_W=1) and 2x3 (DEST_W=2) to reach bad-destination cases.
module tb_switch_route_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_route_arbiter_if #(.NUM_IN(2), .NUM_OUT(2), .DEST_W(1)) a ();
    switch_route_arbiter_if #(.NUM_IN(2), .NUM_OUT(3), .DEST_W(2)) b ();

    switch_route_arbiter #(.NUM_IN(2), .NUM_OUT(2), .DEST_W(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    switch_route_arbiter #(.NUM_IN(2), .NUM_OUT(3), .DEST_W(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: owner -1 means the output is free.
    int m_owner [2][3];
    int m_ptr   [2][3];
    int m_cnt   [2][3];
    bit m_ev    [2];
    int m_ec    [2];

    task automatic model_edge(input int d, input int no, input logic [1:0] v,
                              input int d0, input int d1, input logic [2:0] rdy,
                              input logic r);
        int dst [2];
        bit bad;
        bit ab;
        bit found;
        int o;
        int i;
        dst[0] = d0;
        dst[1] = d1;
        if (r) begin
            for (int j = 0; j < 3; j++) begin
                m_owner[d][j] = -1;
                m_ptr[d][j]   = 0;
                m_cnt[d][j]   = 0;
            end
            m_ev[d] = 1'b0;
            m_ec[d] = 0;
            return;
        end
        bad = 1'b0;
        ab  = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (v[n] && dst[n] >= no) bad = 1'b1;
        end
        for (int j = 0; j < no; j++) begin
            if (m_owner[d][j] < 0) begin
                found = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    i = (m_ptr[d][j] + k) % 2;
                    if (!found && v[i] && dst[i] == j) begin
                        m_owner[d][j] = i;
                        found = 1'b1;
                    end
                end
            end else begin
                o = m_owner[d][j];
                if (v[o] && rdy[j]) begin
                    if (m_cnt[d][j] < 65535) m_cnt[d][j]++;
                    m_ptr[d][j]   = (o + 1) % 2;
                    m_owner[d][j] = -1;
                end else if (!v[o]) begin
                    m_owner[d][j] = -1;
                    ab = 1'b1;
                end
            end
        end
        if (!m_ev[d]) begin
            if (bad) begin
                m_ev[d] = 1'b1;
                m_ec[d] = 1;
            end else if (ab) begin
                m_ev[d] = 1'b1;
                m_ec[d] = 2;
            end
        end
    endtask

    function automatic logic [5:0] exp_route(input int d);
        logic [5:0] r;
        r = '0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 2; i++)
                if (m_owner[d][j] == i) r[j*2 + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] exp_busy(input int d);
        logic [2:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) r[j] = (m_owner[d][j] >= 0);
        return r;
    endfunction

    function automatic logic [47:0] exp_stat(input int d);
        logic [47:0] r;
        r = '0;
`ifdef LOOM_SWITCH_ARB_STATS_EN
        for (int j = 0; j < 3; j++) r[j*16 +: 16] = 16'(m_cnt[d][j]);
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0, 2, a.in_valid, int'(a.in_dest[0]), int'(a.in_dest[1]),
                   {1'b0, a.out_ready}, rst);
        model_edge(1, 3, b.in_valid, int'(b.in_dest[1:0]), int'(b.in_dest[3:2]),
                   b.out_ready, rst);
        #1;
    endtask

    task automatic do_reset();
        a.in_valid = '0; a.in_dest = '0; a.out_ready = '0;
        b.in_valid = '0; b.in_dest = '0; b.out_ready = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) tick();
        n_checks++;
        if (a.route_table !== 4'b0000) $display("FAIL reset_route got=%b exp=0000", a.route_table);
        else n_pass++;
        n_checks++;
        if (a.error_valid !== 1'b0) $display("FAIL reset_err_valid got=%b exp=0", a.error_valid);
        else n_pass++;
        n_checks++;
        if (a.error_code !== 16'h0000) $display("FAIL reset_err_code got=%h exp=0000", a.error_code);
        else n_pass++;
        n_checks++;
        if (a.busy !== 2'b00 || a.stat_xfer !== 32'h0) $display("FAIL reset_busy_stat got=%b/%h exp=00/0", a.busy, a.stat_xfer);
        else n_pass++;
        n_checks++;
        if (b.route_table !== 6'b0 || b.error_valid !== 1'b0) $display("FAIL reset_dut3 got=%b/%b exp=0/0", b.route_table, b.error_valid);
        else n_pass++;
    endtask

    task automatic test_diagonal();
        logic [31:0] st_exp;
        do_reset();
        a.in_valid = 2'b11; a.in_dest = 2'b10; a.out_ready = 2'b11;
        tick();
        n_checks++;
        if (a.route_table !== 4'b1001) $display("FAIL diag_grant got=%b exp=1001", a.route_table);
        else n_pass++;
        tick();
        n_checks++;
        if (a.route_table !== 4'b0000) $display("FAIL diag_release got=%b exp=0000", a.route_table);
        else n_pass++;
`ifdef LOOM_SWITCH_ARB_STATS_EN
        st_exp = {16'd1, 16'd1};
`else
        st_exp = 32'h0;
`endif
        n_checks++;
        if (a.stat_xfer !== st_exp) $display("FAIL diag_stat got=%h exp=%h", a.stat_xfer, st_exp);
        else n_pass++;
        a.in_valid = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] seq [6];
        seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        a.in_valid = 2'b11; a.in_dest = 2'b00; a.out_ready = 2'b01;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (a.route_table !== {2'b00, seq[c]})
                $display("FAIL rr_cycle%0d got=%b exp=%b", c, a.route_table, {2'b00, seq[c]});
            else n_pass++;
        end
        a.in_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] st_exp;
        do_reset();
        a.in_valid = 2'b01; a.in_dest = 2'b01; a.out_ready = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (a.route_table !== 4'b0100) $display("FAIL bp_hold%0d got=%b exp=0100", c, a.route_table);
            else n_pass++;
        end
        a.out_ready = 2'b10;
        tick();
        n_checks++;
        if (a.route_table !== 4'b0000) $display("FAIL bp_release got=%b exp=0000", a.route_table);
        else n_pass++;
`ifdef LOOM_SWITCH_ARB_STATS_EN
        st_exp = {16'd1, 16'd0};
`else
        st_exp = 32'h0;
`endif
        n_checks++;
        if (a.stat_xfer !== st_exp) $display("FAIL bp_stat got=%h exp=%h", a.stat_xfer, st_exp);
        else n_pass++;
        a.in_valid = 2'b00;
        tick();
    endtask

    task automatic test_bad_dest();
        do_reset();
        b.in_valid = 2'b01; b.in_dest = 4'b0011; b.out_ready = 3'b000;
        tick();
        n_checks++;
        if (b.error_valid !== 1'b1 || b.error_code !== 16'h0001)
            $display("FAIL bad_dest_err got=%b/%h exp=1/0001", b.error_valid, b.error_code);
        else n_pass++;
        n_checks++;
        if (b.route_table !== 6'b0) $display("FAIL bad_dest_nogrant got=%b exp=000000", b.route_table);
        else n_pass++;
        b.in_dest = 4'b0000;
        tick();
        n_checks++;
        if (b.route_table !== 6'b000001) $display("FAIL bad_then_grant got=%b exp=000001", b.route_table);
        else n_pass++;
        b.in_valid = 2'b00;
        tick();
        n_checks++;
        if (b.route_table !== 6'b0 || b.error_code !== 16'h0001)
            $display("FAIL bad_then_abandon got=%b/%h exp=000000/0001", b.route_table, b.error_code);
        else n_pass++;
    endtask

    task automatic test_abandon();
        do_reset();
        a.in_valid = 2'b01; a.in_dest = 2'b00; a.out_ready = 2'b00;
        tick();
        n_checks++;
        if (a.route_table !== 4'b0001) $display("FAIL abandon_grant got=%b exp=0001", a.route_table);
        else n_pass++;
        a.in_valid = 2'b00;
        tick();
        n_checks++;
        if (a.error_valid !== 1'b1 || a.error_code !== 16'h0002)
            $display("FAIL abandon_err got=%b/%h exp=1/0002", a.error_valid, a.error_code);
        else n_pass++;
        n_checks++;
        if (a.route_table !== 4'b0000 || a.busy !== 2'b00)
            $display("FAIL abandon_clear got=%b/%b exp=0000/00", a.route_table, a.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        a.in_valid = 2'b01; a.in_dest = 2'b00; a.out_ready = 2'b01;
        tick();
        tick();
        a.out_ready = 2'b00;
        tick();
        n_checks++;
        if (a.route_table !== 4'b0001) $display("FAIL rstmid_pre got=%b exp=0001", a.route_table);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (a.route_table !== 4'b0000 || a.busy !== 2'b00 || a.error_valid !== 1'b0 || a.stat_xfer !== 32'h0)
            $display("FAIL rstmid_clear got=%b/%b/%b/%h exp=0000/00/0/0",
                     a.route_table, a.busy, a.error_valid, a.stat_xfer);
        else n_pass++;
        a.in_valid = 2'b11;
        tick();
        n_checks++;
        if (a.route_table !== 4'b0001) $display("FAIL rstmid_ptr got=%b exp=0001", a.route_table);
        else n_pass++;
        a.in_valid = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [5:0]  er;
        logic [2:0]  eb;
        logic [47:0] es;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(63) == 0);
            a.in_valid  = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            a.in_dest   = 2'($urandom);
            a.out_ready = 2'($urandom);
            b.in_valid  = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            b.in_dest   = {2'($urandom_range(2)), 2'($urandom_range(3))};
            b.out_ready = 3'($urandom);
            tick();
            er = exp_route(0);
            eb = exp_busy(0);
            es = exp_stat(0);
            n_checks++;
            if (a.route_table !== er[3:0] || a.busy !== eb[1:0])
                $display("FAIL rnd2_route n=%0d got=%b/%b exp=%b/%b", n, a.route_table, a.busy, er[3:0], eb[1:0]);
            else n_pass++;
            n_checks++;
            if (a.error_valid !== m_ev[0] || a.error_code !== 16'(m_ec[0]))
                $display("FAIL rnd2_err n=%0d got=%b/%h exp=%b/%h", n, a.error_valid, a.error_code, m_ev[0], 16'(m_ec[0]));
            else n_pass++;
            n_checks++;
            if (a.stat_xfer !== es[31:0])
                $display("FAIL rnd2_stat n=%0d got=%h exp=%h", n, a.stat_xfer, es[31:0]);
            else n_pass++;
            er = exp_route(1);
            eb = exp_busy(1);
            es = exp_stat(1);
            n_checks++;
            if (b.route_table !== er || b.busy !== eb)
                $display("FAIL rnd3_route n=%0d got=%b/%b exp=%b/%b", n, b.route_table, b.busy, er, eb);
            else n_pass++;
            n_checks++;
            if (b.error_valid !== m_ev[1] || b.error_code !== 16'(m_ec[1]))
                $display("FAIL rnd3_err n=%0d got=%b/%h exp=%b/%h", n, b.error_valid, b.error_code, m_ev[1], 16'(m_ec[1]));
            else n_pass++;
            n_checks++;
            if (b.stat_xfer !== es)
                $display("FAIL rnd3_stat n=%0d got=%h exp=%h", n, b.stat_xfer, es);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_contention();
        test_backpressure();
        test_bad_dest();
        test_abandon();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
